// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM state encoding, default timing constants and the hex segment table.
package seg_pkg;

    // Two-state scan FSM: guard time with every anode off, then one digit lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // 1 ms digit on-time and 10 us guard time at 100 MHz.
    localparam int SCAN_DIV_DEFAULT  = 100000;
    localparam int BLANK_DIV_DEFAULT = 1000;

    // Cycle counter width; covers both dividers up to 131071.
    localparam int CNT_W = 17;

    // Active-high segment patterns, bit order g..a, for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex-nibble to seven-segment decoder (active-high, g..a).
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    // Straight table lookup; polarity inversion is left to the caller.
    always_comb begin
        o_pattern = SEG_TABLE[i_nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Alternates an all-off guard period with one lit digit, walks the digits
// 0..3, and displays a per-frame snapshot of the inputs with optional
// leading-zero suppression. All display outputs are registered.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLANK_DIV = BLANK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_DIV - 1);

    // Scan state
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_first;

    // Input snapshot
    logic [15:0]      r_snap_din;
    logic [3:0]       r_snap_dp;
    logic             r_snap_lz;

    // Registered outputs
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_tick;

    // Next-state and decode signals
    state_t           w_state_next;
    logic             w_done;
    logic             w_wrap;
    logic             w_load;
    logic [1:0]       w_idx_next;
    logic [15:0]      w_din_next;
    logic [3:0]       w_dp_next;
    logic             w_lz_next;
    logic [15:0]      w_upper;
    logic [3:0]       w_nibble;
    logic             w_blank_digit;
    logic [6:0]       w_pattern;
    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_out_next;

    seg_hex_dec u_hex_dec (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    // Next state, digit index and the snapshot value that will be in effect
    // after this edge. Display decode looks at the post-load snapshot so a
    // digit entered on the same edge as a load already shows the new data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a
        // combinational output unassigned, which would infer a latch.
        w_state_next = r_state;
        w_done       = (r_state == ST_ON) ? (r_cnt == SCAN_LAST)
                                          : (r_cnt == BLANK_LAST);
        if (w_done) begin
            w_state_next = (r_state == ST_ON) ? ST_BLANK : ST_ON;
        end

        w_wrap     = (r_state == ST_ON) && w_done && (r_idx == 2'd3);
        w_idx_next = ((r_state == ST_ON) && w_done) ? r_idx + 2'd1 : r_idx;
        w_load     = r_first || w_wrap;

        w_din_next = w_load ? din   : r_snap_din;
        w_dp_next  = w_load ? dp_in : r_snap_dp;
        w_lz_next  = w_load ? lz_en : r_snap_lz;

        // Digit i is blank under suppression when nibbles i..3 are all zero.
        w_upper       = w_din_next >> {w_idx_next, 2'b00};
        w_nibble      = w_upper[3:0];
        w_blank_digit = w_lz_next && (w_idx_next != 2'd0) && (w_upper == 16'h0000);
    end

    // Active-low output values for the state being entered.
    always_comb begin
        w_an_next     = 4'hF;
        w_seg_next    = 7'h7F;
        w_dp_out_next = 1'b1;
        if ((w_state_next == ST_ON) && !w_blank_digit) begin
            w_an_next     = ~(4'b0001 << w_idx_next);
            w_seg_next    = ~w_pattern;
            w_dp_out_next = ~w_dp_next[w_idx_next];
        end
    end

    // FSM state, divider counter and digit index.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
            r_idx   <= w_idx_next;
            r_first <= 1'b0;
        end
    end

    // Input snapshot, loaded once after reset and at every frame wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_din <= '0;
            r_snap_dp  <= '0;
            r_snap_lz  <= 1'b0;
        end else if (w_load) begin
            r_snap_din <= din;
            r_snap_dp  <= dp_in;
            r_snap_lz  <= lz_en;
        end
    end

    // Registered display outputs and the frame marker, aligned with the
    // edge that enters the new state or loads the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= 4'hF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_out_next;
            r_frame_tick <= w_load;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
